// File: rtl/sfp_aurora_framer.sv
// Bridges the flat SFP handler stream to the Aurora 64-bit AXI4-Stream user interface:
// TX serialises a captured stream into per-slave packets, RX reassembles and frames-checks it.
module sfp_aurora_framer #(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_NUMBER_OF_SLAVE  = 3,
  parameter int C_NUMBER_OF_FRAME  = 7,
  parameter int C_DATA_STREAM_BIT  = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_SLAVE * C_NUMBER_OF_FRAME,
  parameter int C_RX_TIMEOUT       = 1023
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_channel_up,
  input  logic [C_DATA_STREAM_BIT-1:0]  i_stream_data,
  input  logic                          i_tx_start_flag,
  output logic                          o_tx_busy,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic [C_DATA_STREAM_BIT-1:0]  o_stream_data,
  output logic                          o_rx_end_flag,
  output logic                          o_rx_err,
  output logic [15:0]                   o_rx_err_cnt
);

  localparam int W      = C_AXIS_TDATA_WIDTH;
  localparam int NBEATS = C_NUMBER_OF_SLAVE * C_NUMBER_OF_FRAME;
  localparam int BW     = $clog2(NBEATS);
  localparam int IW     = $clog2(C_RX_TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEATS - 1);
  localparam logic [BW-1:0] FRAME_N    = BW'(C_NUMBER_OF_FRAME);
  localparam logic [BW-1:0] FRAME_LAST = BW'(C_NUMBER_OF_FRAME - 1);
  localparam logic [IW-1:0] TO_LIMIT   = IW'(C_RX_TIMEOUT);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          b_q, b_d;
  logic                   load_tx;
  logic [C_DATA_STREAM_BIT-1:0] shadow_q;
  logic [W-1:0]           tx_beat [NBEATS];

  logic [BW-1:0]          r_q, r_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic                   wr_en, commit;
  logic                   err_q, err_d;
  logic                   end_q, end_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   rx_exp_last;
  logic [W-1:0]           asm_q [NBEATS];
  logic [C_DATA_STREAM_BIT-1:0] commit_flat;
  logic [C_DATA_STREAM_BIT-1:0] stream_q;

  for (genvar k = 0; k < NBEATS; k++) begin : g_beats
    assign tx_beat[k] = shadow_q[k*W +: W];
    // The final beat is never parked in the assembly; it goes straight into the commit.
    if (k == NBEATS - 1) begin : g_last
      assign commit_flat[k*W +: W] = s_axis_tdata;
    end else begin : g_body
      assign commit_flat[k*W +: W] = asm_q[k];
    end
  end

  // ---------------- TX serialiser ----------------
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    load_tx = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_tx_start_flag && i_channel_up) begin
          state_d = ST_SEND;
          b_d     = '0;
          load_tx = 1'b1;
        end
      end
      ST_SEND: begin
        if (!i_channel_up) begin
          state_d = ST_IDLE;
          b_d     = '0;
        end else if (m_axis_tready) begin
          if (b_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            b_d     = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      b_q      <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      if (load_tx) shadow_q <= i_stream_data;
    end
  end

  assign m_axis_tvalid = (state_q == ST_SEND);
  assign o_tx_busy     = m_axis_tvalid;
  assign m_axis_tdata  = m_axis_tvalid ? tx_beat[b_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && ((b_q % FRAME_N) == FRAME_LAST);

  // ---------------- RX reassembly ----------------
  assign rx_exp_last = ((r_q % FRAME_N) == FRAME_LAST);

  always_comb begin
    r_d    = r_q;
    idle_d = idle_q;
    err_d  = 1'b0;
    end_d  = 1'b0;
    wr_en  = 1'b0;
    commit = 1'b0;
    if (!i_channel_up) begin
      r_d    = '0;
      idle_d = '0;
    end else if (s_axis_tvalid) begin
      idle_d = '0;
      if (s_axis_tlast != rx_exp_last) begin
        err_d = 1'b1;
        r_d   = '0;
      end else if (r_q == LAST_BEAT) begin
        commit = 1'b1;
        end_d  = 1'b1;
        r_d    = '0;
      end else begin
        wr_en = 1'b1;
        r_d   = r_q + 1'b1;
      end
    end else if (r_q != '0) begin
      if (idle_q + 1'b1 == TO_LIMIT) begin
        err_d  = 1'b1;
        r_d    = '0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
    cnt_d = (err_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q      <= '0;
      idle_q   <= '0;
      err_q    <= 1'b0;
      end_q    <= 1'b0;
      cnt_q    <= '0;
      stream_q <= '0;
      for (int k = 0; k < NBEATS; k++) asm_q[k] <= '0;
    end else begin
      r_q    <= r_d;
      idle_q <= idle_d;
      err_q  <= err_d;
      end_q  <= end_d;
      cnt_q  <= cnt_d;
      if (wr_en)  asm_q[r_q] <= s_axis_tdata;
      if (commit) stream_q   <= commit_flat;
    end
  end

  assign o_stream_data = stream_q;
  assign o_rx_end_flag = end_q;
  assign o_rx_err      = err_q;
  assign o_rx_err_cnt  = cnt_q;

endmodule

// File: doc/sfp_aurora_framer.md
# sfp_aurora_framer

Bridges the flat SFP stream words used by the SFP handler to the 64-bit AXI4-Stream user interface of the Aurora core. On the TX side, it captures the whole outgoing stream on a start pulse and serialises it into per-slave packets. On the RX side, it reassembles incoming beats into one flat word, checks packet framing, and signals end-of-receive. It sits between the SFP handler and the Aurora IP, in the same clock domain as the handler.

## Interface
- C_AXIS_TDATA_WIDTH, 64, beat width
- C_NUMBER_OF_SLAVE, 3, packets per stream
- C_NUMBER_OF_FRAME, 7, beats per packet
- C_DATA_STREAM_BIT, C_AXIS_TDATA_WIDTH*C_NUMBER_OF_SLAVE*C_NUMBER_OF_FRAME, flat stream width (1344)
- C_RX_TIMEOUT, 1023, idle cycles tolerated inside a partially received stream
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_channel_up  in  1  Aurora channel up
- i_stream_data  in  C_DATA_STREAM_BIT  TX stream from SFP handler
- i_tx_start_flag  in  1  TX start pulse
- o_tx_busy  out  1  TX serialisation in progress
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  TX beat
- m_axis_tvalid  out  1  TX valid
- m_axis_tready  in  1  Aurora ready
- m_axis_tlast  out  1  last beat of a packet
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  RX beat
- s_axis_tvalid  in  1  RX valid; there is no ready, so every valid beat is accepted
- s_axis_tlast  in  1  RX packet end
- o_stream_data  out  C_DATA_STREAM_BIT  last complete RX stream (held)
- o_rx_end_flag  out  1  one-cycle pulse: o_stream_data updated
- o_rx_err  out  1  one-cycle pulse: framing error or timeout
- o_rx_err_cnt  out  16  saturating error count

## Operation
- Reset: every output is 0; the TX FSM enters IDLE; beat counters, shadow/assembly registers and the timeout counter are cleared.
- TX FSM states: IDLE and SEND.
  - IDLE → SEND when i_tx_start_flag=1 and i_channel_up=1. In that cycle, i_stream_data is copied to the shadow register and beat index b is set to 0.
  - In SEND: m_axis_tvalid=1 and m_axis_tdata = shadow[b*64 +: 64], so beat 0 carries bits [63:0].
  - m_axis_tlast = 1 when b mod C_NUMBER_OF_FRAME = C_NUMBER_OF_FRAME-1 (beats 6, 13, 20).
  - b increments on tvalid&tready. A transfer at b = 20 returns the FSM to IDLE.
  - tdata and tlast are stable while stalled.
- Start pulses while in SEND, or while i_channel_up=0, are ignored. No queueing.
- i_channel_up falling during SEND: the packet is aborted, the FSM returns to IDLE, and tvalid drops the next cycle.
- o_tx_busy = (state == SEND).
- RX path:
  - Beat counter r runs 0..20. Each valid beat is written to assembly[r*64 +: 64].
  - Expected tlast = (r mod 7 == 6).
  - If s_axis_tlast differs from the expected value: the error pulse fires, r returns to 0, and the assembly is discarded. o_stream_data is untouched.
  - A valid beat at r = 20 with correct tlast commits the whole stream: o_stream_data <= assembly (including the current beat), o_rx_end_flag pulses, and r returns to 0.
- RX timeout:
  - The idle counter clears on each valid beat and increments on each cycle with r ≠ 0 and no valid beat.
  - When it reaches C_RX_TIMEOUT: error pulse, r = 0, counter cleared.
- i_channel_up=0 resets r and the idle counter with no error.
- o_rx_err_cnt increments on each error pulse and saturates at 0xFFFF. It clears only on reset.
- A good commit and a framing error cannot coincide, because only one beat is handled per cycle.

## Timing
- TX start at cycle T: beat 0 is valid at T+1. With tready held at 1, beats occupy T+1..T+21.
- o_tx_busy is high T+1..T+21. The earliest accepted new start is at T+22, one idle cycle after the final transfer.
- RX final beat accepted at cycle R: o_stream_data is new and o_rx_end_flag=1 at R+1, for exactly one cycle.
- Framing error on a beat at cycle R: o_rx_err=1 at R+1.
- Timeout: last beat at R with no further valid beats gives o_rx_err=1 at R+C_RX_TIMEOUT+1.
- Reset asserted mid-operation: all outputs read 0 from the cycle after i_rst is sampled high.

## Test plan
- i_stream_data beat k = {32'hA5A5_0000+k, 32'h0}, start, tready=1 → 21 beats in order, tlast on beats 6/13/20, busy high 21 cycles.
- Same stream with tready toggling 1,0 → tdata held during stalls, exactly 21 transfers, second start at the last-beat cycle ignored.
- RX: 21 beats of pattern k, tlast on 6/13/20 → o_stream_data matches at R+1, o_rx_end_flag one cycle, o_rx_err=0.
- RX: tlast on beat 4 → o_rx_err pulse, o_rx_err_cnt=1, o_stream_data unchanged; the following good stream still commits.
- RX: 10 beats, then silence → o_rx_err at exactly R+1024; a subsequent full stream commits correctly.
- Reset at TX beat 10 → tvalid=0 next cycle, busy=0; a new start transmits from beat 0 (bits [63:0]).
